// File: rtl/dec_alu_seq_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : dec_alu_seq_pkg                                    |
// | Description : Shared defaults and FSM state type for the         |
// |               sequential decrement unit.                         |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
package dec_alu_seq_pkg;

   // Default operand/result width and step-count width.
   localparam int DEF_WIDTH = 8;
   localparam int DEF_CNT_W = 4;

   // Operation sequencing: wait for operand, count down, hold result.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage : dec_alu_seq_pkg
`default_nettype wire

// File: rtl/dec_alu_seq_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : dec_alu_seq_if                                     |
// | Description : Operand/result handshake bundle of the sequential  |
// |               decrement unit. "slave" is the unit's view,        |
// |               "master" is the producer/consumer view.            |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
interface dec_alu_seq_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
);
   // Input side: operand and step count
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] numa;
   logic [CNT_W-1:0] steps;

   // Output side: result and flags
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] outa;
   logic             borrow;
   logic             zero;

   // Status
   logic             busy;

   modport slave (
      input  in_valid, numa, steps, out_ready,
      output in_ready, out_valid, outa, borrow, zero, busy
   );

   modport master (
      output in_valid, numa, steps, out_ready,
      input  in_ready, out_valid, outa, borrow, zero, busy
   );

endinterface : dec_alu_seq_if
`default_nettype wire

// File: rtl/dec_alu_seq_dec_step.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : dec_step                                           |
// | Description : Combinational single-step decrement, a-1 modulo    |
// |               2^WIDTH, flagging the wrap from zero to all-ones.  |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module dec_step #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a_i,
   output logic [WIDTH-1:0] y_o,
   output logic             borrow_o
);

   // Wraps naturally: 0 - 1 gives all-ones, and that is exactly the borrow case.
   assign y_o      = a_i - WIDTH'(1);
   assign borrow_o = (a_i == '0);

endmodule : dec_step
`default_nettype wire

// File: rtl/dec_alu_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : dec_alu_seq                                        |
// | Description : Sequential decrement unit. Accepts an operand and  |
// |               a step count, subtracts one per clock, and holds   |
// |               the result with sticky borrow and zero flags until |
// |               the consumer takes it.                             |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module dec_alu_seq
   import dec_alu_seq_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic          clk,
   input  logic          rst_n,
   dec_alu_seq_if.slave  bus
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] acc_q,   acc_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic             brw_q,   brw_d;

   logic [WIDTH-1:0] dec_y;
   logic             dec_borrow;

   // The only arithmetic in the unit: one decrement applied to the accumulator.
   dec_step #(
      .WIDTH (WIDTH)
   ) u_dec_step (
      .a_i      (acc_q),
      .y_o      (dec_y),
      .borrow_o (dec_borrow)
   );

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         brw_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         brw_q   <= brw_d;
      end
   end

   // Next-state and datapath update: load on accept, count down in RUN, hold in DONE.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      brw_d   = brw_q;

      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               acc_d   = bus.numa;
               cnt_d   = bus.steps;
               brw_d   = 1'b0;
               state_d = (bus.steps == '0) ? DONE : RUN;
            end
         end

         RUN: begin
            acc_d = dec_y;
            cnt_d = cnt_q - CNT_W'(1);
            // Borrow is sticky: once the operand wraps it stays flagged.
            if (dec_borrow) begin
               brw_d = 1'b1;
            end
            if (cnt_q == CNT_W'(1)) begin
               state_d = DONE;
            end
         end

         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Flags are only meaningful with a finished result, so they are gated by DONE.
   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.outa      = acc_q;
   assign bus.borrow    = (state_q == DONE) && brw_q;
   assign bus.zero      = (state_q == DONE) && (acc_q == '0);

endmodule : dec_alu_seq
`default_nettype wire

// File: doc/dec_alu_seq.md
Name: dec_alu_seq

Overview:
- Sequential decrement unit; the counterpart to the team's combinational +1 incrementer.
- Accepts an operand and a step count over a valid/ready input handshake.
- Subtracts 1 per clock for the requested number of steps, wrapping modulo 2^WIDTH.
- Presents the result, with borrow and zero flags, on a valid/ready output handshake.
- Sits beside the incrementer in the ALU datapath, for countdown and address-rewind operations.

Parameters:
- WIDTH, 8, operand and result width in bits.
- CNT_W, 4, step-count width; at most 2^CNT_W-1 decrements per operation.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  numa and steps are valid this cycle.
- in_ready  out  1  unit can accept an operand (high only in IDLE).
- numa  in  WIDTH  operand to decrement.
- steps  in  CNT_W  number of decrements to apply.
- out_valid  out  1  outa, borrow and zero hold a finished result.
- out_ready  in  1  consumer takes the result this cycle.
- outa  out  WIDTH  result, numa - steps mod 2^WIDTH.
- borrow  out  1  operation wrapped below zero at least once.
- zero  out  1  outa == 0.
- busy  out  1  state is RUN or DONE.

Behaviour:
- Reset (asynchronous, while rst_n=0):
  - state=IDLE; acc=0; cnt=0; borrow register=0.
  - out_valid=0, borrow=0, zero=0, busy=0, outa=0.
  - in_ready=1 as soon as reset is applied.
- FSM states: IDLE, RUN, DONE.
  - in_ready = (state==IDLE); out_valid = (state==DONE); busy = !IDLE.
- IDLE: on the edge where in_valid && in_ready, the unit accepts the operation (accept edge E0):
  - acc<=numa; cnt<=steps; borrow register cleared.
  - Next state is DONE if steps==0, otherwise RUN.
- RUN: each edge:
  - acc<=acc-1; cnt<=cnt-1.
  - If acc==0 on that edge, set the borrow register (sticky); acc wraps to all-ones.
  - When cnt==1 on an edge, next state is DONE.
- Latency: out_valid rises after edge E0+steps. For steps=0 it is the cycle right after accept; at most 2^CNT_W-1 cycles.
- DONE:
  - outa=acc; borrow=borrow register; zero=(acc==0).
  - All three stay stable until the edge with out_ready=1, then next state is IDLE.
  - in_ready returns high in the following cycle. No back-to-back accept on the same edge; maximum throughput is one operation per steps+2 cycles.
- Outside DONE: borrow=0 and zero=0; outa shows acc, which is not meaningful.
- in_valid outside IDLE is ignored; operand inputs are sampled only at E0.
- Width rule: all arithmetic is modulo 2^WIDTH with no saturation. Example: numa=0, steps=15 gives outa=0xF1, borrow=1.
- Reset during RUN or DONE aborts the operation. No out_valid is produced, and the aborted operand is lost.
- out_ready held high before DONE has no effect.

Decomposition:
- Shared package holds:
  - WIDTH and CNT_W defaults.
  - The state enum {IDLE, RUN, DONE}.
- One natural sub-module, dec_step: combinational a-1 with borrow_out=(a==0). It is the mirror of the incrementer and is instantiated once on acc.

Test Plan:
- Basic: numa=0x05, steps=3, out_ready=1 -> out_valid after E0+3; outa=0x02, borrow=0, zero=0; in_ready=1 next cycle.
- Zero result: numa=0x02, steps=2 -> outa=0x00, zero=1, borrow=0.
- Wrap: numa=0x01, steps=3 -> outa=0xFE, borrow=1, zero=0. Also numa=0x00, steps=15 -> outa=0xF1, borrow=1.
- Zero steps: numa=0xA5, steps=0 -> out_valid in the cycle after accept; outa=0xA5, borrow=0, zero=0.
- Backpressure: result ready with out_ready=0 for 5 cycles, in_valid=1 with numa=0x33 throughout:
  - outa, borrow and zero stay stable; in_ready=0; 0x33 is not taken.
  - After out_ready=1: IDLE, then 0x33 is accepted on the next edge.
- Reset mid-op: numa=0x10, steps=10, rst_n=0 at E0+4 -> all outputs 0 immediately, in_ready=1; out_valid never rises for that operation.
